dance_round_ctrl: RTL and testbench

Round sequencer for the dance game. It picks the boss pose each beat from a free-running LFSR and opens a judgment window. It compares the player's switch pose against the boss pose and keeps BCD score and lives. It drives the boss sprite renderer (pose code), the seven-segment decoders (score digits) and game-over indication.

---
 rtl/dance_round_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dance_round_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dance_round_ctrl.sv
// dance_round_ctrl: beat sequencer for the dance game (boss pose pick, judgment window, BCD score, lives).
// Optional macro DANCE_SPEEDUP_EN: judgment window halves at scores 10, 20 and 30.
module dance_round_ctrl #(
   parameter int unsigned BEAT_CYCLES  = 25000000,
   parameter int unsigned JUDGE_CYCLES = 12500000,
   parameter int unsigned LIVES        = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] player_pose,
   output logic [1:0] boss_pose,
   output logic       pose_valid,
   output logic       hit,
   output logic       miss,
   output logic [3:0] score_ones,
   output logic [3:0] score_tens,
   output logic [1:0] lives,
   output logic       game_over,
   output logic [1:0] state
);

   localparam int unsigned      CNT_W      = $clog2(BEAT_CYCLES + 1);
   localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BEAT_CYCLES - 1);
   localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PICK,
      S_JUDGE,
      S_HOLD,
      S_OVER
   } fsm_t;

   fsm_t             cur;
   fsm_t             nxt;
   logic [7:0]       lfsr;
   logic             lfsr_fb;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] win_last;
   logic [1:0]       new_pose;
   logic             pose_match;
   logic             do_pick;
   logic             do_load;
   logic             do_hit;
   logic             do_miss;
   logic [1:0]       state_d;

   assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign pose_match = (player_pose == boss_pose);
   // Inverting both bits guarantees the new pose differs from the current one.
   assign new_pose   = (lfsr[1:0] == boss_pose) ? ~lfsr[1:0] : lfsr[1:0];

`ifdef DANCE_SPEEDUP_EN
   logic [CNT_W-1:0] win;
   logic [1:0]       win_shift;

   assign win_shift = (score_tens >= 4'd3) ? 2'd3 : score_tens[1:0];
   assign win_last  = win - 1'b1;

   // Window is latched from the score seen in PICK and held for the whole beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         win <= CNT_W'(JUDGE_CYCLES);
      end else if (do_pick) begin
         win <= CNT_W'(JUDGE_CYCLES) >> win_shift;
      end
   end
`else
   assign win_last = CNT_W'(JUDGE_CYCLES - 1);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= S_IDLE;
      end else begin
         cur <= nxt;
      end
   end

   always_comb begin
      nxt     = cur;
      do_pick = 1'b0;
      do_load = 1'b0;
      do_hit  = 1'b0;
      do_miss = 1'b0;
      case (cur)
         S_IDLE, S_OVER: begin
            if (start) begin
               nxt     = S_PICK;
               do_load = 1'b1;
            end
         end
         S_PICK: begin
            nxt     = S_JUDGE;
            do_pick = 1'b1;
         end
         S_JUDGE: begin
            if (pose_match) begin
               do_hit = 1'b1;
               nxt    = S_HOLD;
            end else if (cnt == win_last) begin
               do_miss = 1'b1;
               nxt     = (lives <= 2'd1) ? S_OVER : S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt == BEAT_LAST) begin
               nxt = S_PICK;
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_comb begin
      state_d = 2'b00;
      case (nxt)
         S_PICK:  state_d = 2'b01;
         S_JUDGE: state_d = 2'b10;
         S_HOLD:  state_d = 2'b11;
         default: state_d = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr       <= 8'hA5;
         cnt        <= '0;
         boss_pose  <= 2'b01;
         pose_valid <= 1'b0;
         hit        <= 1'b0;
         miss       <= 1'b0;
         score_ones <= '0;
         score_tens <= '0;
         lives      <= LIVES_INIT;
         game_over  <= 1'b0;
         state      <= 2'b00;
      end else begin
         lfsr       <= {lfsr[6:0], lfsr_fb};
         pose_valid <= do_pick;
         hit        <= do_hit;
         miss       <= do_miss;
         game_over  <= (nxt == S_OVER);
         state      <= state_d;

         if (do_pick) begin
            cnt       <= '0;
            boss_pose <= new_pose;
         end else if (cur == S_JUDGE || cur == S_HOLD) begin
            cnt <= cnt + 1'b1;
         end

         if (do_load) begin
            score_ones <= '0;
            score_tens <= '0;
            lives      <= LIVES_INIT;
         end else if (do_hit) begin
            // BCD increment saturating at 99.
            if (score_ones != 4'd9) begin
               score_ones <= score_ones + 4'd1;
            end else if (score_tens != 4'd9) begin
               score_ones <= '0;
               score_tens <= score_tens + 4'd1;
            end
         end else if (do_miss && lives != 2'd0) begin
            lives <= lives - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_dance_round_ctrl.sv
// Testbench for dance_round_ctrl: randomized beats checked against a transaction-level game model.
module tb_dance_round_ctrl;

   localparam int unsigned BEAT   = 16;
   localparam int unsigned JUDGE  = 8;
   localparam int unsigned NLIVES = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] player_pose = 2'b00;
   logic [1:0] boss_pose;
   logic       pose_valid;
   logic       hit;
   logic       miss;
   logic [3:0] score_ones;
   logic [3:0] score_tens;
   logic [1:0] lives;
   logic       game_over;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dance_round_ctrl #(
      .BEAT_CYCLES (BEAT),
      .JUDGE_CYCLES(JUDGE),
      .LIVES       (NLIVES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .player_pose(player_pose),
      .boss_pose  (boss_pose),
      .pose_valid (pose_valid),
      .hit        (hit),
      .miss       (miss),
      .score_ones (score_ones),
      .score_tens (score_tens),
      .lives      (lives),
      .game_over  (game_over),
      .state      (state)
   );

   // Reference LFSR sequence and cycle counter, advanced once per clock.
   logic [7:0] m_lfsr = 8'hA5;
   logic [7:0] lfsr_prev_cycle = 8'hA5;
   int         ncyc = 0;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always @(posedge clk) begin
      lfsr_prev_cycle <= m_lfsr;
      m_lfsr          <= reset ? 8'hA5 : lfsr_step(m_lfsr);
      ncyc            <= ncyc + 1;
   end

   // Game model
   logic [1:0] exp_pose;
   int         exp_score;
   int         exp_lives;
   bit         chain;
   int         last_pv;

   function automatic int exp_window();
`ifdef DANCE_SPEEDUP_EN
      int t;
      t = exp_score / 10;
      if (t > 3) t = 3;
      return int'(JUDGE >> t);
`else
      return int'(JUDGE);
`endif
   endfunction

   function automatic logic [17:0] reset_vec();
      return {2'b01, 4'd0, 4'd0, 2'(NLIVES), 2'b00, 4'b0000};
   endfunction

   function automatic logic [17:0] out_vec();
      return {boss_pose, score_tens, score_ones, lives, state, game_over, hit, miss, pose_valid};
   endfunction

   task automatic model_reset();
      exp_pose  = 2'b01;
      exp_score = 0;
      exp_lives = NLIVES;
      chain     = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_score = 0;
      exp_lives = NLIVES;
      chain     = 1'b0;
      checks++;
      if ({state, score_tens, score_ones, lives} !== {2'b01, 4'd0, 4'd0, 2'(NLIVES)}) begin
         errors++;
         $display("FAIL start_load: state/tens/ones/lives=%b/%0d/%0d/%0d required 01/0/0/%0d",
                  state, score_tens, score_ones, lives, NLIVES);
      end
      @(negedge clk);
      checks++;
      if (pose_valid !== 1'b1) begin
         errors++;
         $display("FAIL start_latency: pose_valid=%b two cycles after start, required 1", pose_valid);
      end
   endtask

   // One beat: k is the cnt value at which the player first matches (<0: random hit inside window).
   task automatic play_beat(input int k);
      int         w;
      int         judge_at;
      int         score_sat;
      bit         exp_hit;
      bit         found;
      bit         spurious;
      logic [1:0] l;
      logic [1:0] want;
      found = 1'b0;
      for (int i = 0; i < int'(2 * BEAT + 4); i++) begin
         if (pose_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL pose_valid_timeout: no pose_valid within %0d cycles, required a pulse", 2 * BEAT + 4);
         return;
      end
      l    = lfsr_prev_cycle[1:0];
      want = (l == exp_pose) ? (l ^ 2'b11) : l;
      if ({boss_pose, state} !== {want, 2'b10}) begin
         errors++;
         $display("FAIL new_pose: boss_pose/state=%b/%b required %b/10 (prev %b)", boss_pose, state, want, exp_pose);
      end
      exp_pose = want;
      if (chain) begin
         checks++;
         if (ncyc - last_pv != int'(BEAT) + 1) begin
            errors++;
            $display("FAIL beat_period: pose_valid spacing=%0d required %0d", ncyc - last_pv, BEAT + 1);
         end
      end
      last_pv = ncyc;
      chain   = 1'b1;

      w = exp_window();
      if (k < 0) k = $urandom_range(w - 1, 0);
      exp_hit  = (k < w);
      judge_at = exp_hit ? k : w - 1;
      player_pose = exp_pose ^ 2'($urandom_range(3, 1));
      spurious = 1'b0;
      for (int i = 0; i <= judge_at; i++) begin
         if (i == k) player_pose = exp_pose;
         if (hit !== 1'b0 || miss !== 1'b0 || (i > 0 && pose_valid !== 1'b0)) spurious = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (spurious) begin
         errors++;
         $display("FAIL early_pulse: hit/miss/pose_valid seen before judgment at cnt=%0d, required none", judge_at);
      end

      if (exp_hit) begin
         score_sat = exp_score + 1;
         exp_score = (score_sat > 99) ? 99 : score_sat;
      end else if (exp_lives > 0) begin
         exp_lives--;
      end
      checks++;
      if ({hit, miss} !== {exp_hit, !exp_hit}) begin
         errors++;
         $display("FAIL judge_pulse: hit/miss=%b%b required %b%b (k=%0d w=%0d)", hit, miss, exp_hit, !exp_hit, k, w);
      end
      checks++;
      if ({score_tens, score_ones, lives, state, game_over} !==
          {4'(exp_score / 10), 4'(exp_score % 10), 2'(exp_lives),
           (exp_lives == 0) ? 2'b00 : 2'b11, exp_lives == 0}) begin
         errors++;
         $display("FAIL judge_state: tens/ones/lives/state/go=%0d/%0d/%0d/%b/%b required %0d/%0d/%0d/%b/%b",
                  score_tens, score_ones, lives, state, game_over, exp_score / 10, exp_score % 10,
                  exp_lives, (exp_lives == 0) ? 2'b00 : 2'b11, exp_lives == 0);
      end
      if (!exp_hit && k < int'(BEAT)) player_pose = exp_pose;
      @(negedge clk);
      checks++;
      if ({hit, miss} !== 2'b00) begin
         errors++;
         $display("FAIL pulse_width: hit/miss=%b%b one cycle after judgment, required 00", hit, miss);
      end
      player_pose = exp_pose ^ 2'b01;
      if (exp_lives == 0) chain = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (out_vec() !== reset_vec()) begin
            errors++;
            $display("FAIL reset_idle: outputs=%h required %h at idle cycle %0d", out_vec(), reset_vec(), i);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_first_hit();
      do_start();
      play_beat(3);
      play_beat(3);
   endtask

   task automatic test_game_over();
      while (exp_lives > 0) play_beat(99);
      for (int i = 0; i < 20; i++) begin
         player_pose = 2'($urandom);
         @(negedge clk);
         checks++;
         if ({boss_pose, game_over, state, pose_valid, hit, miss} !== {exp_pose, 1'b1, 2'b00, 3'b000}) begin
            errors++;
            $display("FAIL over_frozen: pose/go/state/pv/hit/miss=%b/%b/%b/%b%b%b required %b/1/00/000",
                     boss_pose, game_over, state, pose_valid, hit, miss, exp_pose);
         end
      end
      do_start();
   endtask

   task automatic test_boundary();
      play_beat(int'(JUDGE) - 1);
      play_beat(int'(JUDGE));
   endtask

   task automatic test_saturation();
      do_reset();
      do_start();
      for (int i = 0; i < 100; i++) play_beat(-1);
      checks++;
      if ({score_tens, score_ones} !== 8'h99) begin
         errors++;
         $display("FAIL saturate: score=%0d%0d required 99", score_tens, score_ones);
      end
   endtask

   task automatic test_random();
      do_reset();
      do_start();
      for (int i = 0; i < 40; i++) begin
         play_beat(int'($urandom_range(11, 0)));
         if (exp_lives == 0) do_start();
      end
   endtask

`ifdef DANCE_SPEEDUP_EN
   task automatic test_speedup();
      do_reset();
      do_start();
      for (int i = 0; i < 10; i++) play_beat(-1);
      play_beat(5);
      play_beat(3);
   endtask
`endif

   task automatic test_reset_mid();
      bit found;
      do_reset();
      do_start();
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (pose_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL reset_mid_wait: no pose_valid after start, required a pulse");
      end
      player_pose = boss_pose ^ 2'b10;
      @(negedge clk);
      player_pose = boss_pose;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (out_vec() !== reset_vec()) begin
         errors++;
         $display("FAIL reset_mid: outputs=%h required %h", out_vec(), reset_vec());
      end
      reset = 1'b0;
      model_reset();
      player_pose = 2'b00;
      repeat (3) @(negedge clk);
      checks++;
      if ({state, hit, miss, pose_valid} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_mid_idle: state/hit/miss/pv=%b/%b%b%b required 00/000", state, hit, miss, pose_valid);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      last_pv = 0;
      test_reset();
      test_first_hit();
      test_game_over();
      test_boundary();
      test_saturation();
      test_random();
`ifdef DANCE_SPEEDUP_EN
      test_speedup();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
